// File: rtl/trig_seq_ctrl.sv
// Multi-stage trigger sequencer: up to four masked compare stages with per-stage sample
// offsets, followed by a post-trigger capture window. Optional watchdog: TRIG_TIMEOUT_EN.
module trig_seq_ctrl #(
  parameter int CNT_W   = 17,
  parameter int DATA_W  = 33,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              busy,
  output logic [1:0]        stage,
  output logic              triggered,
  output logic              capture_en,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  value_q [4];
  logic [DATA_W-1:0]  value_d [4];
  logic [DATA_W-1:0]  mask_q [4];
  logic [DATA_W-1:0]  mask_d [4];
  logic [CNT_W-1:0]   offset_q [4];
  logic [CNT_W-1:0]   offset_d [4];
  logic [1:0]         num_stages_q, num_stages_d;
  logic [CNT_W-1:0]   post_count_q, post_count_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         stage_q, stage_d;
  logic               busy_q, busy_d;
  logic               trig_q, trig_d;
  logic               cap_q, cap_d;
  logic               done_q, done_d;
  logic               cfg_open;
  logic               match;
  logic               last_stage;

`ifdef TRIG_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  assign cfg_open   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign match      = (data & mask_q[stage_q]) == (value_q[stage_q] & mask_q[stage_q]);
  assign last_stage = (stage_q == num_stages_q);

  // Register file: writes land only while the sequencer is not running.
  always_comb begin
    value_d      = value_q;
    mask_d       = mask_q;
    offset_d     = offset_q;
    num_stages_d = num_stages_q;
    post_count_d = post_count_q;
    if (cfg_we && cfg_open) begin
      case (cfg_addr[1:0])
        2'd0:    value_d[cfg_addr[3:2]]  = cfg_wdata;
        2'd1:    mask_d[cfg_addr[3:2]]   = cfg_wdata;
        2'd2:    offset_d[cfg_addr[3:2]] = cfg_wdata[CNT_W-1:0];
        default: begin
          if (cfg_addr[3:2] == 2'd0)      num_stages_d = cfg_wdata[1:0];
          else if (cfg_addr[3:2] == 2'd1) post_count_d = cfg_wdata[CNT_W-1:0];
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
`ifdef TRIG_TIMEOUT_EN
    wd_d    = wd_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d = ST_ARMED;
          stage_d = 2'd0;
          cnt_d   = '0;
`ifdef TRIG_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ST_ARMED: begin
        if (sample_valid) begin
          if (cnt_q != offset_q[stage_q]) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (match) begin
            cnt_d = '0;
            if (last_stage) begin
              trig_d  = 1'b1;
              state_d = (post_count_q == '0) ? ST_DONE : ST_POST;
            end else begin
              stage_d = stage_q + 2'd1;
            end
          end else begin
            stage_d = 2'd0;
            cnt_d   = '0;
          end
        end
`ifdef TRIG_TIMEOUT_EN
        // A final match on the expiry cycle wins over the watchdog.
        if (!trig_d) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            stage_d = 2'd0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
`endif
      end
      ST_POST: begin
        if (sample_valid) begin
          if (cnt_q == post_count_q - CNT_W'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      stage_d = 2'd0;
      cnt_d   = '0;
      trig_d  = 1'b0;
`ifdef TRIG_TIMEOUT_EN
      wd_d    = '0;
      tmo_d   = 1'b0;
`endif
    end
    busy_d = (state_d == ST_ARMED) || (state_d == ST_POST);
    cap_d  = (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      for (int k = 0; k < 4; k++) begin
        value_q[k]  <= '0;
        mask_q[k]   <= '0;
        offset_q[k] <= '0;
      end
      num_stages_q <= '0;
      post_count_q <= '0;
      cnt_q        <= '0;
      stage_q      <= '0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
      cap_q        <= 1'b0;
      done_q       <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
      wd_q         <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      mask_q       <= mask_d;
      offset_q     <= offset_d;
      num_stages_q <= num_stages_d;
      post_count_q <= post_count_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      busy_q       <= busy_d;
      trig_q       <= trig_d;
      cap_q        <= cap_d;
      done_q       <= done_d;
`ifdef TRIG_TIMEOUT_EN
      wd_q         <= wd_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign stage      = stage_q;
  assign triggered  = trig_q;
  assign capture_en = cap_q;
  assign done       = done_q;
`ifdef TRIG_TIMEOUT_EN
  assign timeout    = tmo_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Bench for trig_seq_ctrl: directed scenarios plus random traffic, every cycle checked
// against a sample-counting reference model.
module tb_trig_seq_ctrl;
  localparam int CW  = 6;
  localparam int DW  = 33;
  localparam int TMO = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DONE = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          busy, triggered, capture_en, done, timeout;
  logic [1:0]    stage;

  int total = 0;
  int bad = 0;

  // reference model: stage progress expressed as samples still to skip / still to capture
  logic [DW-1:0] mv [4];
  logic [DW-1:0] mm [4];
  int            mo [4];
  int            nst, pc, mode, m_stage, skip, remain, age;
  bit            m_trig, m_tmo, cap_seen;

  trig_seq_ctrl #(.CNT_W(CW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .data(data), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .busy(busy), .stage(stage), .triggered(triggered),
    .capture_en(capture_en), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int k;
    m_trig = 1'b0;
    m_tmo  = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = '0; mm[i] = '0; mo[i] = 0;
      end
      nst = 0; pc = 0; mode = M_IDLE; m_stage = 0; skip = 0; remain = 0; age = 0;
      return;
    end
    if (cfg_we && (mode == M_IDLE || mode == M_DONE)) begin
      k = int'(cfg_addr[3:2]);
      case (cfg_addr[1:0])
        2'd0: mv[k] = cfg_wdata;
        2'd1: mm[k] = cfg_wdata;
        2'd2: mo[k] = int'(cfg_wdata[CW-1:0]);
        default: begin
          if (k == 0) nst = int'(cfg_wdata[1:0]);
          else if (k == 1) pc = int'(cfg_wdata[CW-1:0]);
        end
      endcase
    end
    if (abort) begin
      mode = M_IDLE; m_stage = 0;
      return;
    end
    case (mode)
      M_IDLE, M_DONE: if (arm) begin
        mode = M_ARMED; m_stage = 0; skip = mo[0]; age = 0;
      end
      M_ARMED: begin
        if (sample_valid) begin
          if (skip > 0) skip--;
          else if (((data ^ mv[m_stage]) & mm[m_stage]) == '0) begin
            if (m_stage == nst) begin
              m_trig = 1'b1; remain = pc;
              mode = (pc == 0) ? M_DONE : M_POST;
            end else begin
              m_stage++; skip = mo[m_stage];
            end
          end else begin
            m_stage = 0; skip = mo[0];
          end
        end
`ifdef TRIG_TIMEOUT_EN
        age++;
        if (!m_trig && age >= TMO) begin
          mode = M_IDLE; m_stage = 0; m_tmo = 1'b1;
        end
`endif
      end
      M_POST: if (sample_valid) begin
        remain--;
        if (remain == 0) mode = M_DONE;
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (capture_en === 1'b1) cap_seen = 1'b1;
    chk("busy", 64'(busy), 64'(mode == M_ARMED || mode == M_POST));
    chk("stage", 64'(stage), 64'(m_stage));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("capture_en", 64'(capture_en), 64'(mode == M_POST));
    chk("done", 64'(done), 64'(mode == M_DONE));
    chk("timeout", 64'(timeout), 64'(m_tmo));
  endtask

  task automatic idle_in();
    arm = 0; abort = 0; cfg_we = 0; sample_valid = 0; reset = 0;
  endtask

  task automatic do_reset();
    idle_in(); reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic cfg_wr(input int stg, input int fld, input logic [DW-1:0] val);
    cfg_we = 1; cfg_addr = 4'((stg << 2) | fld); cfg_wdata = val;
    tick();
    cfg_we = 0;
  endtask

  task automatic samp(input logic [DW-1:0] d);
    sample_valid = 1; data = d;
    tick();
    sample_valid = 0;
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic single_cfg(input int val, input int off, input int post);
    do_reset();
    cfg_wr(0, 0, DW'(val));
    cfg_wr(0, 1, '1);
    cfg_wr(0, 2, DW'(off));
    cfg_wr(1, 3, DW'(post));
  endtask

  initial begin
    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_stage", 64'(stage), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_cap", 64'(capture_en), 0);

    // single stage, offset 1, window 3
    single_cfg(4, 1, 3);
    do_arm();
    chk("t1_armed", 64'(busy), 1);
    samp(0);   chk("t1_s0_trig", 64'(triggered), 0);
    samp(4);   chk("t1_trig", 64'(triggered), 1); chk("t1_cap_on", 64'(capture_en), 1);
    samp(7);   chk("t1_cap1", 64'(capture_en), 1);
    samp(7);   chk("t1_cap2", 64'(capture_en), 1);
    samp(7);   chk("t1_cap_off", 64'(capture_en), 0); chk("t1_done", 64'(done), 1);
    samp(9);   chk("t1_done_hold", 64'(done), 1);

    // same with sample_valid low every other cycle
    single_cfg(4, 1, 3);
    do_arm();
    samp(0); tick();
    samp(4); chk("t3_trig", 64'(triggered), 1);
    tick();  chk("t3_trig_pulse", 64'(triggered), 0); chk("t3_cap_gap", 64'(capture_en), 1);
    samp(7); tick(); samp(7); tick();
    chk("t3_cap_mid", 64'(capture_en), 1);
    samp(7); chk("t3_done", 64'(done), 1); chk("t3_cap_off", 64'(capture_en), 0);

    // two stages, mismatch at stage 1 then full match
    do_reset();
    cfg_wr(0, 3, 1);
    cfg_wr(0, 0, 'hA); cfg_wr(0, 1, '1); cfg_wr(0, 2, 0);
    cfg_wr(1, 0, 'hB); cfg_wr(1, 1, '1); cfg_wr(1, 2, 2);
    cfg_wr(1, 3, 2);
    do_arm();
    samp('hA); chk("t2_stage1", 64'(stage), 1);
    samp(DW'($urandom)); samp(DW'($urandom));
    samp('hC); chk("t2_back0", 64'(stage), 0); chk("t2_no_trig", 64'(triggered), 0);
    samp('hA); samp(DW'($urandom)); samp(DW'($urandom));
    samp('hB); chk("t2_trig", 64'(triggered), 1);

    // abort during POST, then arm+abort together
    single_cfg(4, 0, 10);
    do_arm();
    samp(4);
    for (int i = 0; i < 4; i++) samp(DW'(i));
    abort = 1; samp(5); abort = 0;
    chk("t4_busy", 64'(busy), 0); chk("t4_cap", 64'(capture_en), 0); chk("t4_done", 64'(done), 0);
    arm = 1; abort = 1; tick(); arm = 0; abort = 0;
    chk("t4_arm_abort", 64'(busy), 0);

    // zero window with zero mask: first sample goes straight to DONE
    do_reset();
    cfg_wr(0, 0, 3);
    do_arm();
    cap_seen = 0;
    samp(DW'($urandom));
    chk("t5_trig", 64'(triggered), 1); chk("t5_done", 64'(done), 1);
    samp(1); tick();
    chk("t5_cap_never", 64'(cap_seen), 0);

    // write while busy is dropped
    single_cfg(4, 0, 1);
    do_arm();
    cfg_wr(0, 0, 7);
    samp(7); chk("t5_we_busy_no_trig", 64'(triggered), 0);
    samp(4); chk("t5_we_busy_old_val", 64'(triggered), 1);

    // arm and write in the same cycle: armed run sees the new value
    samp(0);
    cfg_we = 1; cfg_addr = 4'h0; cfg_wdata = 9; arm = 1; tick(); cfg_we = 0; arm = 0;
    samp(4); chk("t6_new_val_no_old", 64'(triggered), 0);
    samp(9); chk("t6_new_val", 64'(triggered), 1);

    // all-ones offset
    single_cfg(5, (1 << CW) - 1, 1);
    do_arm();
    for (int i = 0; i < (1 << CW) - 1; i++) samp(5);
    chk("t7_pre_max", 64'(triggered), 0);
    samp(5); chk("t7_max_off", 64'(triggered), 1);

    // watchdog
    single_cfg(1, 0, 1);
    do_arm();
`ifdef TRIG_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) samp(0);
    chk("t8_pre_tmo", 64'(busy), 1);
    samp(0);
    chk("t8_tmo", 64'(timeout), 1); chk("t8_idle", 64'(busy), 0);
    tick(); chk("t8_tmo_pulse", 64'(timeout), 0);
`else
    for (int i = 0; i < 1000; i++) samp(0);
    chk("t8_still_armed", 64'(busy), 1); chk("t8_no_tmo", 64'(timeout), 0);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      arm          = ($urandom_range(0, 7) == 0);
      cfg_we       = ($urandom_range(0, 3) == 0);
      cfg_addr     = 4'($urandom_range(0, 15));
      cfg_wdata    = DW'($urandom_range(0, 5));
      if (cfg_addr[1:0] == 2'd1 && $urandom_range(0, 1) == 1) cfg_wdata = '1;
      sample_valid = ($urandom_range(0, 9) < 7);
      data         = DW'($urandom_range(0, 5));
      tick();
    end
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_seq_ctrl.md
# trig_seq_ctrl

Multi-stage trigger sequencer for the logic-analyzer capture path. It holds up to four compare stages, each with a value, mask and sample offset. It walks the sampled bus through those stages in order and, on the final match, asserts a capture-enable window of programmable length. It sits between the host configuration interface and the capture memory controller, and replaces single-shot offset/mask comparison with a programmable sequence.

## Interface
Parameters:
- CNT_W, 17: width of offset and post-trigger counters.
- DATA_W, 33: sampled bus width.
- TIMEOUT, 1000000: armed-cycle limit (used only with TRIG_TIMEOUT_EN).

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- data  in  DATA_W  sampled analyzer bus.
- sample_valid  in  1  qualifies `data`; counters and compares advance only when high.
- arm  in  1  start sequence; accepted only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- cfg_we  in  1  config write strobe; ignored unless state is IDLE or DONE.
- cfg_addr  in  4  {stage[1:0], field[1:0]}.
- cfg_wdata  in  DATA_W  config write data.
- busy  out  1  high in ARMED or POST.
- stage  out  2  current stage index.
- triggered  out  1  one-cycle pulse on final-stage match.
- capture_en  out  1  high during POST.
- done  out  1  level, high in DONE.
- timeout  out  1  one-cycle pulse on watchdog expiry.

## Operation
Config fields (field 0 = value, 1 = mask, 2 = offset[CNT_W-1:0], 3 = extra):
- Stage 0 field 3 is num_stages[1:0]. Active stages are num_stages+1.
- Stage 1 field 3 is post_count[CNT_W-1:0].
- All other field-3 writes are ignored.
- Every config register resets to 0. Mask 0 always matches.

Match rule: (data & mask_k) == (value_k & mask_k).

States: IDLE, ARMED, POST, DONE.
- IDLE/DONE + arm: go to ARMED, stage=0, cnt=0, done cleared.
- ARMED, valid sample with cnt != offset_k: cnt increments.
- ARMED, valid sample with cnt == offset_k and a match:
  - If not the last stage: stage increments, cnt=0.
  - If the last stage: triggered pulses. State goes to POST, or to DONE if post_count==0. cnt=0.
- ARMED, valid sample with cnt == offset_k and a mismatch: stage=0, cnt=0. The failing sample is not re-evaluated.
- POST: each valid sample increments cnt. On the sample where cnt == post_count-1, go to DONE. capture_en covers exactly post_count valid samples.
- abort, any state: go to IDLE, all counters cleared. abort beats arm in the same cycle.
- arm in ARMED or POST is ignored.
- Reset values: state IDLE, stage 0, and all outputs 0.

Boundary rules:
- An offset of all ones is legal. cnt cannot pass offset_k, because a compare always occurs at equality.
- Lowering num_stages is only possible in IDLE/DONE, so stage never exceeds num_stages.

## Timing
- All outputs are registered.
- triggered and capture_en rise on the clock edge after the matching sample edge.
- Arm-to-ARMED latency is 1 cycle. The first compare-eligible sample is the one with sample_valid high on the cycle after arm.
- With offset_k=0, stage k compares its first valid sample after entry.
- A config write takes effect on the next cycle. Arm and cfg_we in the same cycle: the write is applied and ARMED uses the new value.
- If reset is asserted mid-sequence, the next cycle is IDLE with config cleared.

## Configuration
Macro: TRIG_TIMEOUT_EN.
- Defined: a cycle counter (not sample-qualified) runs in ARMED. When it reaches TIMEOUT-1 cycles without a final match, the FSM goes to IDLE and timeout pulses for one cycle. The counter clears on entry to ARMED.
- Undefined: no watchdog, ARMED persists indefinitely, and timeout is tied to 0.

## Test plan
- Single stage, value=4, mask=all ones, offset=1, post_count=3. Arm, then drive valid samples 0,4,7,7,7,9. Required: triggered on the edge after the second sample, capture_en for exactly three valid samples, then done=1.
- Two stages: stage0 value=0xA offset 0, stage1 value=0xB offset 2. Drive A,x,x,C. Required: mismatch at stage 1 returns stage to 0 with no trigger. Then drive A,x,x,B. Required: triggered.
- Run the single-stage case with sample_valid low every other cycle. Required: offsets and the post window count valid samples only, giving the same trigger sample index.
- Assert abort during POST with post_count=10 at the 5th sample. Required: next cycle IDLE, capture_en=0, done=0. Assert arm together with abort. Required: still IDLE.
- Set post_count=0 and mask=0. Arm. Required: first valid sample triggers, state goes straight to DONE, capture_en never high. A cfg_we while busy leaves registers unchanged.
- With TRIG_TIMEOUT_EN and TIMEOUT=16, arm with a never-matching value. Required: timeout pulse and IDLE 16 cycles after ARMED entry. Without the macro, still ARMED after 1000 cycles.
